// File: rtl/cp0_vectored_if.sv
// CP0 register-access and interrupt bundle shared by the
// datapath (master) and the coprocessor-0 block (slave).
interface cp0_vectored_if #(
    parameter int NUM_IRQ  = 4,
    parameter int PC_WIDTH = 30
);
    logic [31:0]         wr_data;
    logic [4:0]          regnum;
    logic                MTC0;
    logic                ERET;
    logic [PC_WIDTH-1:0] next_pc;
    logic [NUM_IRQ-1:0]  irq;
    logic [31:0]         rd_data;
    logic [PC_WIDTH-1:0] EPC;
    logic                TakenInterrupt;

    modport master (
        output wr_data, regnum, MTC0, ERET,
        output next_pc, irq,
        input  rd_data, EPC, TakenInterrupt
    );

    modport slave (
        input  wr_data, regnum, MTC0, ERET,
        input  next_pc, irq,
        output rd_data, EPC, TakenInterrupt
    );
endinterface

// File: rtl/cp0_vectored.sv
// Coprocessor 0 with edge-latched external interrupts, a
// Count/Compare timer on line 7 and taken-line ID capture.
module cp0_vectored #(
    parameter int NUM_IRQ  = 4,
    parameter int PC_WIDTH = 30
) (
    input logic           clock,
    input logic           reset,
    cp0_vectored_if.slave bus
);
    localparam logic [6:0] EXT = 7'((8'd1 << NUM_IRQ) - 8'd1);

    logic [31:0]         count_q, count_d;
    logic [31:0]         compare_q, compare_d;
    logic [7:0]          im_q, im_d;
    logic [7:0]          ip_q, ip_d;
    logic                ie_q, ie_d;
    logic                exl_q, exl_d;
    logic [2:0]          id_q, id_d;
    logic [PC_WIDTH-1:0] epc_q, epc_d;
    logic [NUM_IRQ-1:0]  irq_q;

    logic [7:0] pend;
    logic [6:0] rise, clr;
    logic [2:0] top;
    logic       take, match;
    logic       wr_cnt, wr_cmp, wr_sr;
    logic       wr_cause, wr_epc;

    assign wr_cnt   = bus.MTC0 && bus.regnum == 5'd9;
    assign wr_cmp   = bus.MTC0 && bus.regnum == 5'd11;
    assign wr_sr    = bus.MTC0 && bus.regnum == 5'd12;
    assign wr_cause = bus.MTC0 && bus.regnum == 5'd13;
    assign wr_epc   = bus.MTC0 && bus.regnum == 5'd14;

    assign pend  = ip_q & im_q;
    assign take  = ie_q & ~exl_q & (|pend);
    assign match = count_q == compare_q;
    assign rise  = 7'(bus.irq & ~irq_q);

    assign bus.TakenInterrupt = take;
    assign bus.EPC            = epc_q;

    // Ascending scan: the last hit is the highest line.
    always_comb begin
        top = '0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) top = 3'(i);
        end
    end

    always_comb begin
        count_d   = wr_cnt ? bus.wr_data : count_q + 32'd1;
        compare_d = wr_cmp ? bus.wr_data : compare_q;
        clr       = wr_cause ? bus.wr_data[14:8] : '0;
        ip_d[6:0] = ((ip_q[6:0] & ~clr) | rise) & EXT;
        ip_d[7]   = match | (ip_q[7] & ~wr_cmp);
        ie_d      = wr_sr ? bus.wr_data[0] : ie_q;
        im_d      = wr_sr ? bus.wr_data[15:8] & {1'b1, EXT}
                          : im_q;
        priority case (1'b1)
            take:     exl_d = 1'b1;
            bus.ERET: exl_d = 1'b0;
            wr_sr:    exl_d = bus.wr_data[1];
            default:  exl_d = exl_q;
        endcase
        epc_d = epc_q;
        if (take)        epc_d = bus.next_pc;
        else if (wr_epc) epc_d = bus.wr_data[PC_WIDTH+1:2];
        id_d = take ? top : id_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '1;
            im_q      <= '0;
            ip_q      <= '0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            id_q      <= '0;
            epc_q     <= '0;
            irq_q     <= '0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            im_q      <= im_d;
            ip_q      <= ip_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            id_q      <= id_d;
            epc_q     <= epc_d;
            irq_q     <= bus.irq;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.regnum)
            5'd9:  bus.rd_data = count_q;
            5'd11: bus.rd_data = compare_q;
            5'd12: bus.rd_data = {16'b0, im_q, 6'b0, exl_q, ie_q};
            5'd13: bus.rd_data = {16'b0, ip_q, 3'b0, id_q, 2'b0};
            5'd14: bus.rd_data = 32'({epc_q, 2'b00});
            default: bus.rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_vectored.sv
// Bench for cp0_vectored: directed steps then random traffic,
// two instances (4 and 2 lines) against a rule-based model.
module tb_cp0_vectored;
    localparam logic [7:0] L4 = 8'h8F;
    localparam logic [7:0] L2 = 8'h83;

    typedef struct packed {
        logic [31:0] cnt;
        logic [31:0] cmp;
        logic [7:0]  im;
        logic [7:0]  ip;
        logic        ie;
        logic        exl;
        logic [2:0]  id;
        logic [29:0] epc;
        logic [6:0]  irqh;
    } ms_t;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    bit   chk_on = 1'b0;
    bit   exp_on = 1'b0;
    logic [31:0] exp4, exp2;
    logic [3:0]  cur_irq = '0;
    ms_t  m4, m2;

    cp0_vectored_if #(.NUM_IRQ(4), .PC_WIDTH(30)) b4 ();
    cp0_vectored_if #(.NUM_IRQ(2), .PC_WIDTH(30)) b2 ();

    cp0_vectored #(.NUM_IRQ(4), .PC_WIDTH(30)) dut4 (
        .clock(clock), .reset(reset), .bus(b4)
    );
    cp0_vectored #(.NUM_IRQ(2), .PC_WIDTH(30)) dut2 (
        .clock(clock), .reset(reset), .bus(b2)
    );

    always #5 clock = ~clock;

    function automatic logic m_take(ms_t s);
        return s.ie && !s.exl && ((s.ip & s.im) != 8'h00);
    endfunction

    function automatic logic [2:0] m_top(logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic logic [31:0] m_read(ms_t s, logic [4:0] r);
        case (r)
            5'd9:  return s.cnt;
            5'd11: return s.cmp;
            5'd12: return {16'b0, s.im, 6'b0, s.exl, s.ie};
            5'd13: return {16'b0, s.ip, 3'b0, s.id, 2'b0};
            5'd14: return {s.epc, 2'b00};
            default: return 32'h0;
        endcase
    endfunction

    // Later rules override earlier ones, giving the priorities.
    function automatic ms_t m_step(
        ms_t s, bit r, bit w, bit e, logic [4:0] rn,
        logic [31:0] wd, logic [29:0] npc, logic [6:0] ir,
        logic [7:0] legal
    );
        ms_t n;
        if (r) begin
            n = '0;
            n.cmp = 32'hFFFF_FFFF;
            return n;
        end
        n = s;
        n.cnt = s.cnt + 32'd1;
        n.irqh = ir;
        if (w) begin
            case (rn)
                5'd9:  n.cnt = wd;
                5'd11: begin n.cmp = wd; n.ip[7] = 1'b0; end
                5'd12: begin
                    n.ie  = wd[0];
                    n.exl = wd[1];
                    n.im  = wd[15:8] & legal;
                end
                5'd13: n.ip[6:0] = s.ip[6:0] & ~wd[14:8];
                5'd14: n.epc = wd[31:2];
                default: ;
            endcase
        end
        if (e) n.exl = 1'b0;
        n.ip[6:0] = n.ip[6:0] | (ir & ~s.irqh & legal[6:0]);
        if (s.cnt == s.cmp) n.ip[7] = 1'b1;
        if (m_take(s)) begin
            n.exl = 1'b1;
            n.epc = npc;
            n.id  = m_top(s.ip & s.im);
        end
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs,
                         logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(bit r, bit w, bit e, logic [4:0] rn,
                        logic [31:0] wd, logic [29:0] npc,
                        logic [3:0] ir);
        reset = r;
        b4.MTC0 = w;  b2.MTC0 = w;
        b4.ERET = e;  b2.ERET = e;
        b4.regnum = rn;  b2.regnum = rn;
        b4.wr_data = wd; b2.wr_data = wd;
        b4.next_pc = npc; b2.next_pc = npc;
        b4.irq = ir;  b2.irq = ir[1:0];
        cur_irq = ir;
        @(negedge clock);
        if (chk_on) begin
            check("take4", 32'(b4.TakenInterrupt), 32'(m_take(m4)));
            check("take2", 32'(b2.TakenInterrupt), 32'(m_take(m2)));
            check("rd4", b4.rd_data, m_read(m4, rn));
            check("rd2", b2.rd_data, m_read(m2, rn));
            check("epc4", 32'(b4.EPC), 32'(m4.epc));
            check("epc2", 32'(b2.EPC), 32'(m2.epc));
        end
        if (exp_on) begin
            check("dir4", b4.rd_data, exp4);
            check("dir2", b2.rd_data, exp2);
            exp_on = 1'b0;
        end
        @(posedge clock);
        m4 = m_step(m4, r, w, e, rn, wd, npc, {3'b0, ir}, L4);
        m2 = m_step(m2, r, w, e, rn, wd, npc, {5'b0, ir[1:0]}, L2);
        #1;
    endtask

    task automatic peek(logic [4:0] rn, logic [31:0] e4,
                        logic [31:0] e2);
        exp_on = 1'b1;
        exp4 = e4;
        exp2 = e2;
        tick(0, 0, 0, rn, 32'h0, 30'h0, cur_irq);
    endtask

    task automatic wr(logic [4:0] rn, logic [31:0] wd,
                      logic [3:0] ir);
        tick(0, 1, 0, rn, wd, 30'h0, ir);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m4 = '0;
        m2 = '0;
        tick(1, 0, 0, 5'd0, 32'h0, 30'h0, 4'h0);
        chk_on = 1'b1;
        tick(1, 0, 0, 5'd9, 32'h0, 30'h0, 4'h0);
        peek(5'd9, 32'h0, 32'h0);
        peek(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        peek(5'd12, 32'h0, 32'h0);
        peek(5'd9, 32'd3, 32'd3);
        peek(5'd13, 32'h0, 32'h0);
        peek(5'd14, 32'h0, 32'h0);

        // irq[1] edge, taken, then held without a second take
        wr(5'd12, 32'h0000_0301, 4'h0);
        tick(0, 0, 0, 5'd13, 32'h0, 30'h0, 4'h2);
        tick(0, 0, 0, 5'd13, 32'h0, 30'h100, 4'h2);
        peek(5'd14, 32'h400, 32'h400);
        peek(5'd13, 32'h204, 32'h204);
        peek(5'd12, 32'h303, 32'h303);
        tick(0, 0, 0, 5'd12, 32'h0, 30'h0, 4'h0);
        wr(5'd13, 32'h200, 4'h0);
        tick(0, 0, 1, 5'd12, 32'h0, 30'h0, 4'h0);

        // timer and irq[0] together, then re-take after ERET
        wr(5'd12, 32'h0000_8301, 4'h0);
        wr(5'd11, m4.cnt + 32'd2, 4'h0);
        tick(0, 0, 0, 5'd9, 32'h0, 30'h0, 4'h0);
        tick(0, 0, 0, 5'd9, 32'h0, 30'h0, 4'h1);
        tick(0, 0, 0, 5'd13, 32'h0, 30'h200, 4'h1);
        peek(5'd13, 32'h811C, 32'h811C);
        tick(0, 1, 1, 5'd11, 32'hFFFF_FFFF, 30'h0, 4'h1);
        tick(0, 0, 0, 5'd13, 32'h0, 30'h300, 4'h1);
        peek(5'd13, 32'h100, 32'h100);

        // cause W1C with and without a same-cycle edge
        wr(5'd13, 32'h100, 4'h1);
        peek(5'd13, 32'h0, 32'h0);
        tick(0, 0, 0, 5'd13, 32'h0, 30'h0, 4'h0);
        wr(5'd13, 32'h100, 4'h1);
        peek(5'd13, 32'h100, 32'h100);

        // EPC write loses to a same-cycle take
        tick(0, 0, 1, 5'd12, 32'h0, 30'h0, 4'h1);
        tick(0, 1, 0, 5'd14, 32'h1234, 30'h55, 4'h1);
        peek(5'd14, 32'h154, 32'h154);

        wr(5'd12, 32'h0000_FF03, 4'h1);
        peek(5'd12, 32'h8F03, 32'h8303);
        wr(5'd9, 32'hFFFF_FFFE, 4'h1);
        peek(5'd9, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        peek(5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        peek(5'd9, 32'h0, 32'h0);

        // reset while EXL=1, against concurrent writes
        tick(1, 1, 1, 5'd12, 32'h0000_FFFF, 30'h7, 4'h0);
        peek(5'd9, 32'h0, 32'h0);
        peek(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        peek(5'd12, 32'h0, 32'h0);
        peek(5'd13, 32'h0, 32'h0);
        peek(5'd14, 32'h0, 32'h0);

        for (int k = 0; k < 600; k++) begin
            bit          r, w, e;
            logic [4:0]  rn;
            logic [31:0] wd;
            logic [3:0]  ir;
            r = ($urandom_range(0, 63) == 0);
            w = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0: rn = 5'd9;
                1: rn = 5'd11;
                2: rn = 5'd12;
                3: rn = 5'd13;
                4: rn = 5'd14;
                default: rn = 5'($urandom);
            endcase
            wd = $urandom;
            if (rn == 5'd11 && $urandom_range(0, 1) == 1)
                wd = m4.cnt + 32'($urandom_range(0, 4));
            ir = cur_irq;
            if ($urandom_range(0, 2) == 0) ir = 4'($urandom);
            tick(r, w, e, rn, wd, 30'($urandom), ir);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
